// File: rtl/watch_pkg.sv
// Shared types and helpers for the digital-watch mode controller.
package watch_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME,
    SHOW_ALARM,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY
  } state_t;

  localparam logic [3:0] NOKEY = 4'd10;

  // Codes 11-15 are not digits and behave like NOKEY.
  function automatic logic is_digit(input logic [3:0] k);
    return (k != NOKEY) && (k <= 4'd9);
  endfunction

endpackage

// File: rtl/sec_timeout_counter.sv
// Saturating counter of one_second ticks; expired while the count sits at LIMIT.
module sec_timeout_counter #(
  parameter int unsigned LIMIT = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  input  logic tick,
  output logic expired
);

  localparam int unsigned W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && tick && (count != W'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == W'(LIMIT));

endmodule

// File: rtl/watch_mode_controller.sv
// Key-entry / mode FSM for the digital watch; all outputs registered.
// Define FAST_SET_EN to build the time_button hold detector driving fast_watch.
module watch_mode_controller
  import watch_pkg::*;
#(
  parameter int unsigned TIMEOUT_SECS = 10
`ifdef FAST_SET_EN
  ,
  parameter int unsigned HOLD_SECS    = 2
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  input  logic       one_second,
  output logic       shift,
  output logic       show_new_time,
  output logic       show_a,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       reset_count,
  output logic       fast_watch
);

  state_t state;
  logic   digit;
  logic   timeout;
  logic   fast_hold;

  assign digit = is_digit(key);

  sec_timeout_counter #(
    .LIMIT (TIMEOUT_SECS)
  ) u_entry_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   ((state == KEY_STORED) || (state == SHOW_TIME)),
    .en      ((state == KEY_WAITED) || (state == KEY_ENTRY)),
    .tick    (one_second),
    .expired (timeout)
  );

`ifdef FAST_SET_EN
  logic hold_expired;

  sec_timeout_counter #(
    .LIMIT (HOLD_SECS)
  ) u_hold_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   ((state != SHOW_TIME) || !time_button),
    .en      ((state == SHOW_TIME) && time_button),
    .tick    (one_second),
    .expired (hold_expired)
  );

  assign fast_hold = hold_expired && time_button;
`else
  assign fast_hold = 1'b0;
`endif

  // Outputs are set on the same edge as the state they belong to, so load
  // pulses coincide with the return to SHOW_TIME.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= SHOW_TIME;
      shift         <= 1'b0;
      show_new_time <= 1'b0;
      show_a        <= 1'b0;
      load_new_a    <= 1'b0;
      load_new_c    <= 1'b0;
      reset_count   <= 1'b0;
      fast_watch    <= 1'b0;
    end else begin
      shift       <= 1'b0;
      load_new_a  <= 1'b0;
      load_new_c  <= 1'b0;
      reset_count <= 1'b0;
      fast_watch  <= 1'b0;
      case (state)
        SHOW_TIME: begin
          if (alarm_button) begin
            state  <= SHOW_ALARM;
            show_a <= 1'b1;
          end else if (digit) begin
            state         <= KEY_STORED;
            shift         <= 1'b1;
            show_new_time <= 1'b1;
          end else begin
            fast_watch <= fast_hold;
          end
        end
        SHOW_ALARM: begin
          if (!alarm_button) begin
            state  <= SHOW_TIME;
            show_a <= 1'b0;
          end
        end
        KEY_STORED: begin
          state <= KEY_WAITED;
        end
        KEY_WAITED: begin
          if (!digit) begin
            state <= KEY_ENTRY;
          end else if (timeout) begin
            state         <= SHOW_TIME;
            show_new_time <= 1'b0;
          end
        end
        KEY_ENTRY: begin
          if (alarm_button) begin
            state         <= SHOW_TIME;
            show_new_time <= 1'b0;
            load_new_a    <= 1'b1;
          end else if (time_button) begin
            state         <= SHOW_TIME;
            show_new_time <= 1'b0;
            load_new_c    <= 1'b1;
            reset_count   <= 1'b1;
          end else if (digit) begin
            state <= KEY_STORED;
            shift <= 1'b1;
          end else if (timeout) begin
            state         <= SHOW_TIME;
            show_new_time <= 1'b0;
          end
        end
        default: begin
          state         <= SHOW_TIME;
          show_new_time <= 1'b0;
          show_a        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_watch_mode_controller.sv
// Self-checking bench for watch_mode_controller: directed scenarios plus random traffic vs a flag-based model.
module tb_watch_mode_controller;

  localparam int unsigned TO   = 10;
  localparam int unsigned HOLD = 2;
  localparam logic [3:0]  NK   = 4'd10;
`ifdef FAST_SET_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] key = NK;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic       one_second = 1'b0;
  logic       shift, show_new_time, show_a, load_new_a, load_new_c, reset_count, fast_watch;

  always #5 clk = ~clk;

  watch_mode_controller #(
    .TIMEOUT_SECS (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .key           (key),
    .alarm_button  (alarm_button),
    .time_button   (time_button),
    .one_second    (one_second),
    .shift         (shift),
    .show_new_time (show_new_time),
    .show_a        (show_a),
    .load_new_a    (load_new_a),
    .load_new_c    (load_new_c),
    .reset_count   (reset_count),
    .fast_watch    (fast_watch)
  );

  logic [6:0] dut_o;
  assign dut_o = {shift, show_new_time, show_a, load_new_a, load_new_c, reset_count, fast_watch};

  int checks = 0;
  int errors = 0;
  int n_shift, n_la, n_lc, n_rc;

  // Reference model: the watch is either viewing the alarm, idle, or in an
  // entry session (just shifted / waiting for key release / accepting keys).
  bit         m_alarm, m_entry, m_stored, m_waiting;
  int         m_idle, m_hold;
  logic [6:0] exp_o;

  task automatic model_reset();
    m_alarm = 0; m_entry = 0; m_stored = 0; m_waiting = 0;
    m_idle = 0; m_hold = 0;
    exp_o = '0;
  endtask

  task automatic model_step(input logic [3:0] k, input bit ab, input bit tb, input bit os);
    bit dig, to;
    bit e_shift, e_la, e_lc, e_fw;
    int nidle, nhold;
    dig = (k <= 4'd9);
    to  = (m_idle == TO);
    e_shift = 0; e_la = 0; e_lc = 0; e_fw = 0;
    nidle = m_idle;
    nhold = 0;
    if (m_entry && !m_stored) nidle = (m_idle + int'(os) > TO) ? TO : m_idle + int'(os);
    else if (!m_alarm)        nidle = 0;
    if (!m_entry && !m_alarm && tb) nhold = (m_hold + int'(os) > HOLD) ? HOLD : m_hold + int'(os);

    if (m_alarm) begin
      if (!ab) m_alarm = 0;
    end else if (!m_entry) begin
      if (ab) m_alarm = 1;
      else if (dig) begin m_entry = 1; m_stored = 1; e_shift = 1; end
      else e_fw = FAST && (m_hold >= HOLD) && tb;
    end else if (m_stored) begin
      m_stored = 0; m_waiting = 1;
    end else if (m_waiting) begin
      if (!dig) m_waiting = 0;
      else if (to) begin m_entry = 0; m_waiting = 0; end
    end else begin
      if (ab)       begin m_entry = 0; e_la = 1; end
      else if (tb)  begin m_entry = 0; e_lc = 1; end
      else if (dig) begin m_stored = 1; e_shift = 1; end
      else if (to)  m_entry = 0;
    end
    m_idle = nidle;
    m_hold = nhold;
    exp_o = {e_shift, m_entry, m_alarm, e_la, e_lc, e_lc, e_fw};
  endtask

  // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic [3:0] k, input bit ab, input bit tb, input bit os);
    key = k; alarm_button = ab; time_button = tb; one_second = os;
    @(posedge clk);
    model_step(k, ab, tb, os);
    #1;
    n_shift += int'(shift);
    n_la    += int'(load_new_a);
    n_lc    += int'(load_new_c);
    n_rc    += int'(reset_count);
  endtask

  task automatic clear_counts();
    n_shift = 0; n_la = 0; n_lc = 0; n_rc = 0;
  endtask

  task automatic apply_reset();
    key = NK; alarm_button = 0; time_button = 0; one_second = 0;
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    clear_counts();
  endtask

  task automatic test_reset();
    key = NK; alarm_button = 0; time_button = 0; one_second = 0;
    reset_n = 0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dut_o !== 7'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got %b want %b", i, dut_o, 7'b0);
      end
      @(posedge clk); #1;
    end
    reset_n = 1;
    clear_counts();
  endtask

  task automatic test_entry_abort();
    apply_reset();
    drive(4'd3, 0, 0, 0);
    drive(NK, 0, 0, 0);
    drive(NK, 0, 0, 0);
    checks++;
    if (show_new_time !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_entry: show_new_time got %b want 1", show_new_time);
    end
    #2 reset_n = 0;
    model_reset();
    #1;
    checks++;
    if (dut_o !== 7'b0) begin
      errors++;
      $display("FAIL abort_async: got %b want %b", dut_o, 7'b0);
    end
    clear_counts();
    alarm_button = 1; time_button = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({n_la, n_lc} !== {32'd0, 32'd0} || dut_o !== 7'b0) begin
      errors++;
      $display("FAIL abort_no_load: la=%0d lc=%0d outs=%b want 0 0 0000000", n_la, n_lc, dut_o);
    end
    alarm_button = 0; time_button = 0;
    reset_n = 1;
    clear_counts();
  endtask

  task automatic test_digit_entry();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      if (i < 16)       drive((i % 4) < 2 ? 4'(i / 4 + 1) : NK, 0, 0, 0);
      else if (i == 16) drive(NK, 0, 1, 0);
      else              drive(NK, 0, 0, 0);
      checks++;
      if (dut_o !== exp_o) begin
        errors++;
        $display("FAIL digit_entry step %0d: got %b want %b", i, dut_o, exp_o);
      end
    end
    checks++;
    if (n_shift != 4 || n_lc != 1 || n_rc != 1 || n_la != 0) begin
      errors++;
      $display("FAIL digit_entry_counts: shift=%0d lc=%0d rc=%0d la=%0d want 4 1 1 0", n_shift, n_lc, n_rc, n_la);
    end
  endtask

  task automatic test_held_key();
    apply_reset();
    for (int i = 0; i < 23; i++) begin
      drive(i < 20 ? 4'd5 : NK, 0, 0, 0);
      checks++;
      if (dut_o !== exp_o) begin
        errors++;
        $display("FAIL held_key step %0d: got %b want %b", i, dut_o, exp_o);
      end
    end
    checks++;
    if (n_shift != 1) begin
      errors++;
      $display("FAIL held_key_shifts: got %0d want 1", n_shift);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    drive(4'd7, 0, 0, 0);
    drive(NK, 0, 0, 0);
    drive(NK, 0, 0, 0);
    for (int p = 1; p <= TO; p++) begin
      drive(NK, 0, 0, 1);
      for (int j = 0; j < 3; j++) begin
        drive(NK, 0, 0, 0);
        checks++;
        if (dut_o !== exp_o) begin
          errors++;
          $display("FAIL timeout pulse %0d cyc %0d: got %b want %b", p, j, dut_o, exp_o);
        end
      end
      if (p == TO - 1) begin
        checks++;
        if (show_new_time !== 1'b1) begin
          errors++;
          $display("FAIL timeout_early: show_new_time got %b want 1", show_new_time);
        end
      end
    end
    checks++;
    if (show_new_time !== 1'b0 || n_la != 0 || n_lc != 0) begin
      errors++;
      $display("FAIL timeout_exit: snt=%b la=%0d lc=%0d want 0 0 0", show_new_time, n_la, n_lc);
    end
  endtask

  task automatic test_both_buttons();
    apply_reset();
    drive(4'd3, 0, 0, 0);
    drive(NK, 0, 0, 0);
    drive(NK, 0, 0, 0);
    drive(NK, 1, 1, 0);
    checks++;
    if ({load_new_a, load_new_c, reset_count, show_new_time, show_a} !== 5'b10000) begin
      errors++;
      $display("FAIL both_buttons: la lc rc snt sa got %b want 10000",
               {load_new_a, load_new_c, reset_count, show_new_time, show_a});
    end
    drive(NK, 1, 0, 0);
    checks++;
    if ({show_a, load_new_a} !== 2'b10) begin
      errors++;
      $display("FAIL alarm_held_after_load: sa la got %b want 10", {show_a, load_new_a});
    end
    drive(NK, 0, 0, 0);
    checks++;
    if (dut_o !== exp_o || show_a !== 1'b0) begin
      errors++;
      $display("FAIL alarm_release: got %b want %b", dut_o, exp_o);
    end
  endtask

  task automatic test_fast_set();
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      drive(NK, 0, i < 12, (i == 2) || (i == 6));
      checks++;
      if (dut_o !== exp_o) begin
        errors++;
        $display("FAIL fast_set step %0d: got %b want %b", i, dut_o, exp_o);
      end
      if (i == 5 || i == 10 || i == 12) begin
        checks++;
        if (fast_watch !== ((i == 10) ? FAST : 1'b0)) begin
          errors++;
          $display("FAIL fast_watch step %0d: got %b want %b", i, fast_watch, (i == 10) ? FAST : 1'b0);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] k;
    bit ab, tb;
    apply_reset();
    k = NK; ab = 0; tb = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0)
        k = ($urandom_range(0, 2) == 0) ? NK : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0) ab = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0) tb = ($urandom_range(0, 2) == 0);
      drive(k, ab, tb, $urandom_range(0, 7) == 0);
      checks++;
      if (dut_o !== exp_o) begin
        errors++;
        $display("FAIL random cyc %0d: key=%0d ab=%b tb=%b got %b want %b", i, k, ab, tb, dut_o, exp_o);
      end
    end
  endtask

  initial begin
    clear_counts();
    model_reset();
    test_reset();
    test_entry_abort();
    test_digit_entry();
    test_held_key();
    test_timeout();
    test_both_buttons();
    test_fast_set();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
